// File: rtl/fetch_prefetch_queue_if.sv
// rtl/fetch_prefetch_queue_if.sv - fetch/IF-ID handshake bundle for the prefetch queue
// slave = queue side, master = fetch stage / IF-ID side.
interface fetch_prefetch_queue_if #(
  parameter int ADDR_W = 2
);
  logic              i_fetch_valid;
  logic [31:0]       i_fetch_pc;
  logic [31:0]       i_fetch_instr;
  logic              o_fetch_ready;
  logic              o_valid;
  logic [31:0]       o_pc;
  logic [31:0]       o_instr;
  logic              i_ready;
  logic              i_flush;
  logic [ADDR_W:0]   o_level;

  modport slave (
    input  i_fetch_valid, i_fetch_pc, i_fetch_instr, i_ready, i_flush,
    output o_fetch_ready, o_valid, o_pc, o_instr, o_level
  );

  modport master (
    output i_fetch_valid, i_fetch_pc, i_fetch_instr, i_ready, i_flush,
    input  o_fetch_ready, o_valid, o_pc, o_instr, o_level
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - instruction prefetch FIFO between fetch and IF/ID
// Define PREFETCH_BYPASS_EN for zero-latency pass-through when the queue is empty.
module fetch_prefetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input logic                   i_clk,
  input logic                   i_rst,
  fetch_prefetch_queue_if.slave q
);
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [63:0]     mem [DEPTH];
  logic [63:0]     head;
  logic            empty;
  logic            full;
  logic            stored_valid;
  logic            bypass;
  logic            push;
  logic            pop;

  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                        (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign stored_valid = !empty && !q.i_flush;
  assign head         = mem[rd_ptr[ADDR_W-1:0]];

`ifdef PREFETCH_BYPASS_EN
  assign bypass = empty && q.i_fetch_valid && !q.i_flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word taken by IF/ID this cycle is never written to storage.
  assign push = q.i_fetch_valid && !full && !q.i_flush && !(bypass && q.i_ready);
  assign pop  = stored_valid && q.i_ready;

  assign q.o_fetch_ready = !full;
  assign q.o_valid       = stored_valid || bypass;
  assign q.o_pc          = bypass ? q.i_fetch_pc
                                  : (stored_valid ? head[63:32] : 32'h0);
  assign q.o_instr       = bypass ? q.i_fetch_instr
                                  : (stored_valid ? head[31:0] : 32'h0);
  assign q.o_level       = wr_ptr - rd_ptr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (q.i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[ADDR_W-1:0]] <= {q.i_fetch_pc, q.i_fetch_instr};
  end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb/tb_fetch_prefetch_queue.sv - self-checking bench for fetch_prefetch_queue
// Reference model is a plain queue of {pc, instr}; honours PREFETCH_BYPASS_EN.
module tb_fetch_prefetch_queue;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;
`ifdef PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_prefetch_queue_if #(.ADDR_W(ADDR_W)) bus ();

  fetch_prefetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .q     (bus)
  );

  logic [63:0] model_q [$];
  int total  = 0;
  int passed = 0;
  int failed = 0;
  bit accepted;
  bit consumed;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, compare outputs against the model, then advance model and clock.
  task automatic step(input logic fv, input logic [31:0] pc, input logic rdy, input logic fl);
    logic [31:0] ins;
    bit          ev;
    bit          take_byp;
    bit          do_push;
    logic [31:0] epc;
    logic [31:0] ein;
    int          n;
    ins = $urandom;
    bus.i_fetch_valid = fv;
    bus.i_fetch_pc    = pc;
    bus.i_fetch_instr = ins;
    bus.i_ready       = rdy;
    bus.i_flush       = fl;
    #2;
    n   = model_q.size();
    ev  = !fl && (n > 0 || (BYP && fv));
    epc = 32'h0;
    ein = 32'h0;
    if (ev && n > 0) begin
      epc = model_q[0][63:32];
      ein = model_q[0][31:0];
    end else if (ev) begin
      epc = pc;
      ein = ins;
    end
    chk("valid", bus.o_valid, ev);
    chk("pc", bus.o_pc, epc);
    chk("instr", bus.o_instr, ein);
    chk("fetch_ready", bus.o_fetch_ready, n < DEPTH);
    chk("level", bus.o_level, n);
    accepted = 1'b0;
    consumed = 1'b0;
    if (fl) begin
      model_q.delete();
    end else begin
      take_byp = BYP && n == 0 && fv && rdy;
      do_push  = fv && n < DEPTH && !take_byp;
      consumed = ev && rdy;
      if (n > 0 && rdy) void'(model_q.pop_front());
      if (do_push) model_q.push_back({pc, ins});
      accepted = do_push || take_byp;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int pushed;
    int taken;
    bus.i_fetch_valid = 1'b0;
    bus.i_fetch_pc    = 32'h0;
    bus.i_fetch_instr = 32'h0;
    bus.i_ready       = 1'b0;
    bus.i_flush       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", bus.o_valid, 1'b0);
    chk("rst_pc", bus.o_pc, 32'h0);
    chk("rst_instr", bus.o_instr, 32'h0);
    chk("rst_level", bus.o_level, 0);
    chk("rst_ready", bus.o_fetch_ready, 1'b1);

    // asynchronous reset with three entries held
    for (int i = 0; i < 3; i++) step(1'b1, 32'h300 + 4 * i, 1'b0, 1'b0);
    chk("pre_rst_level", bus.o_level, 3);
    bus.i_fetch_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_valid", bus.o_valid, 1'b0);
    chk("midrst_level", bus.o_level, 0);
    chk("midrst_instr", bus.o_instr, 32'h0);
    chk("midrst_ready", bus.o_fetch_ready, 1'b1);
    model_q.delete();
    @(negedge clk);
    rst = 1'b0;

    // fill to full, then a fifth push must be refused
    for (int i = 0; i < 4; i++) step(1'b1, 32'h4 * i, 1'b0, 1'b0);
    chk("full_level", bus.o_level, 4);
    chk("full_ready", bus.o_fetch_ready, 1'b0);
    step(1'b1, 32'h10, 1'b1, 1'b0);
    step(1'b1, 32'h10, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      bus.i_fetch_valid = 1'b0;
      bus.i_ready       = 1'b1;
      #1;
      chk("drain_pc", bus.o_pc, 32'h4 * i);
      step(1'b0, 32'h0, 1'b1, 1'b0);
    end
    chk("drain_pc_tail", bus.o_pc, 32'h10);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("drained_valid", bus.o_valid, 1'b0);
    chk("drained_level", bus.o_level, 0);

    // six pushes and six pops across the pointer wrap
    pushed = 0;
    taken  = 0;
    for (int c = 0; c < 80 && taken < 6; c++) begin
      step((pushed < 6) && ($urandom_range(0, 3) != 0), 32'h100 + 4 * pushed, c[0], 1'b0);
      if (accepted) pushed++;
      if (consumed) taken++;
      chk("wrap_level_max", bus.o_level <= 4, 1'b1);
    end
    chk("wrap_taken", taken, 6);
    chk("wrap_empty", bus.o_level, 0);

    // flush with a concurrent push and pop
    for (int i = 0; i < 3; i++) step(1'b1, 32'h200 + 4 * i, 1'b0, 1'b0);
    step(1'b1, 32'h40, 1'b1, 1'b1);
    chk("post_flush_level", bus.o_level, 0);
    step(1'b1, 32'h80, 1'b0, 1'b0);
    chk("after_flush_pc", bus.o_pc, 32'h80);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // empty queue, push with IF/ID ready
    bus.i_fetch_valid = 1'b1;
    bus.i_fetch_pc    = 32'h20;
    bus.i_ready       = 1'b1;
    #1;
`ifdef PREFETCH_BYPASS_EN
    chk("bypass_same_cycle", bus.o_valid, 1'b1);
`else
    chk("nobypass_same_cycle", bus.o_valid, 1'b0);
`endif
    step(1'b1, 32'h20, 1'b1, 1'b0);
`ifdef PREFETCH_BYPASS_EN
    chk("bypass_level", bus.o_level, 0);
`else
    chk("nobypass_next_pc", bus.o_pc, 32'h20);
`endif
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // randomized traffic with occasional flushes
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1,
           $urandom_range(0, 15) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
